run_length_detector: RTL and testbench

// - CH-channel serial run detector: flags RUN_LEN or more consecutive input bits equal to match_val.
// - Each channel is independent and has a saturating run counter.
// - MEALY selects combinational (same-cycle) or registered (next-cycle) outputs.
// - Successor to the fixed 3-ones Mealy detector; feeds framing/sync-search logic in the serial path.

---
 rtl/run_length_detector_if.sv | 33 +++
 rtl/run_length_detector.sv | 118 +++++++++++
 tb/tb_run_length_detector.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/run_length_detector_if.sv
// run_length_detector_if: sample/result bundle for the run length detector.
//   master (stimulus side): drives en, clr, match_val, x_in; receives y_out, det_pulse[, hits]
//   slave  (detector side): the reverse
//   en        sample enable
//   clr       synchronous clear of all run counters
//   match_val bit value being counted
//   x_in      one serial bit per channel
//   y_out     per-channel run-active level
//   det_pulse per-channel one-cycle detection pulse
//   hits      per-channel detection counters, ch0 in LSBs (only with RUN_DET_STATS_EN)
interface run_length_detector_if #(
  parameter int unsigned CH    = 1,
  parameter int unsigned CNT_W = 8
);
  logic          en;
  logic          clr;
  logic          match_val;
  logic [CH-1:0] x_in;
  logic [CH-1:0] y_out;
  logic [CH-1:0] det_pulse;

`ifdef RUN_DET_STATS_EN
  logic [CH*CNT_W-1:0] hits;

  modport master (output en, clr, match_val, x_in, input  y_out, det_pulse, hits);
  modport slave  (input  en, clr, match_val, x_in, output y_out, det_pulse, hits);
`else
  localparam int unsigned L_CNT_W_UNUSED = CNT_W;

  modport master (output en, clr, match_val, x_in, input  y_out, det_pulse);
  modport slave  (input  en, clr, match_val, x_in, output y_out, det_pulse);
`endif
endinterface

// File: rtl/run_length_detector.sv
// run_length_detector: CH-channel serial run detector. Each channel flags RUN_LEN or
// more consecutive enabled samples equal to match_val, using a saturating run counter.
//   clk  clock, rising edge
//   rst  asynchronous active-low reset
//   bus  run_length_detector_if.slave (en, clr, match_val, x_in -> y_out, det_pulse[, hits])
// MEALY=1 gives same-cycle outputs from state+input, MEALY=0 registers them (one cycle later).
// Optional feature macro RUN_DET_STATS_EN: adds bus.hits, one saturating CNT_W-bit
// detection counter per channel (never cleared by clr).
module run_length_detector #(
  parameter int unsigned CH      = 1,
  parameter int unsigned RUN_LEN = 3,
  parameter int unsigned MEALY   = 1,
  parameter int unsigned CNT_W   = 8
) (
  input logic                  clk,
  input logic                  rst,
  run_length_detector_if.slave bus
);

  localparam int unsigned       CNT_SW = $clog2(RUN_LEN + 1);
  localparam logic [CNT_SW-1:0] L_FULL = CNT_SW'(RUN_LEN);

  logic [CNT_SW-1:0] r_cnt   [CH];
  logic [CNT_SW-1:0] w_cnt_d [CH];
  logic [CH-1:0]     w_full_d;
  logic [CH-1:0]     w_rise;
  logic [CH-1:0]     w_hit;

  // Next run count per channel; clr wins over en, counter saturates at RUN_LEN.
  always_comb begin
    w_full_d = '0;
    w_rise   = '0;
    for (int c = 0; c < CH; c++) begin
      w_cnt_d[c] = r_cnt[c];
      if (bus.clr) begin
        w_cnt_d[c] = '0;
      end else if (bus.en) begin
        if (bus.x_in[c] == bus.match_val) begin
          w_cnt_d[c] = (r_cnt[c] == L_FULL) ? L_FULL : r_cnt[c] + CNT_SW'(1);
        end else begin
          w_cnt_d[c] = '0;
        end
      end
      w_full_d[c] = (w_cnt_d[c] == L_FULL);
      // Only the step into the saturated state counts as a new detection.
      w_rise[c]   = w_full_d[c] && (r_cnt[c] != L_FULL);
    end
  end

  // Run counter state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < CH; c++) r_cnt[c] <= '0;
    end else begin
      for (int c = 0; c < CH; c++) r_cnt[c] <= w_cnt_d[c];
    end
  end

  if (MEALY != 0) begin : g_mealy
    logic [CH-1:0] w_y;

    // en=0 or clr force the combinational outputs low even when the run is saturated.
    assign w_y = w_full_d & {CH{bus.en & ~bus.clr}};

    if (RUN_LEN == 1) begin : g_len1
      logic [CH-1:0] w_rise_unused;
      // A one-bit run is complete on every matching sample, so each one is a detection.
      assign w_hit         = w_y;
      assign w_rise_unused = w_rise;
    end else begin : g_lenn
      assign w_hit = w_rise;
    end

    assign bus.y_out     = w_y;
    assign bus.det_pulse = w_hit;
  end else begin : g_moore
    logic [CH-1:0] r_y;
    logic [CH-1:0] r_det;

    // Registered outputs; with en=0 the count holds so y keeps its value and det drops.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_y   <= '0;
        r_det <= '0;
      end else begin
        r_y   <= w_full_d;
        r_det <= w_rise;
      end
    end

    assign w_hit         = w_rise;
    assign bus.y_out     = r_y;
    assign bus.det_pulse = r_det;
  end

`ifdef RUN_DET_STATS_EN
  logic [CH-1:0][CNT_W-1:0] r_hits;

  // Saturating per-channel detection counters; only reset clears them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hits <= '0;
    end else begin
      for (int c = 0; c < CH; c++) begin
        if (w_hit[c] && (r_hits[c] != '1)) r_hits[c] <= r_hits[c] + CNT_W'(1);
      end
    end
  end

  assign bus.hits = r_hits;
`else
  logic [CH-1:0] w_hit_unused;
  localparam int unsigned L_CNT_W_UNUSED = CNT_W;

  assign w_hit_unused = w_hit;
`endif

endmodule

// File: tb/tb_run_length_detector.sv
// tb_run_length_detector: drives a 2-channel RUN_LEN=3 detector in both output modes and a
// 1-channel RUN_LEN=1 detector from shared stimulus; checks against a run-length model,
// a table of known vectors and hand-written clr/en/reset/counter sequences.
`timescale 1ns/1ps
module tb_run_length_detector;

  localparam int unsigned CH    = 2;
  localparam int          RL    = 3;
  localparam int unsigned CNT_W = 2;
  localparam int          HMAX  = (1 << CNT_W) - 1;
  localparam int          NTBL  = 25;

  typedef struct {
    logic          en;
    logic          clr;
    logic          mv;
    logic [CH-1:0] x;
    logic [CH-1:0] ey;
    logic [CH-1:0] ed;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          en, clr, mv;
  logic [CH-1:0] x;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: length of the current run of enabled matching samples, uncapped (bounded at 1000).
  int            run [CH];
  int            hits_ab [CH];
  int            hits_c;
  logic [CH-1:0] mo_y, mo_det;

  run_length_detector_if #(.CH(CH), .CNT_W(CNT_W)) if_a ();
  run_length_detector_if #(.CH(CH), .CNT_W(CNT_W)) if_b ();
  run_length_detector_if #(.CH(1),  .CNT_W(CNT_W)) if_c ();

  assign if_a.en = en;  assign if_a.clr = clr;  assign if_a.match_val = mv;  assign if_a.x_in = x;
  assign if_b.en = en;  assign if_b.clr = clr;  assign if_b.match_val = mv;  assign if_b.x_in = x;
  assign if_c.en = en;  assign if_c.clr = clr;  assign if_c.match_val = mv;  assign if_c.x_in = x[0];

  run_length_detector #(.CH(CH), .RUN_LEN(RL), .MEALY(1), .CNT_W(CNT_W)) u_mealy (
    .clk(clk), .rst(rst), .bus(if_a.slave));
  run_length_detector #(.CH(CH), .RUN_LEN(RL), .MEALY(0), .CNT_W(CNT_W)) u_moore (
    .clk(clk), .rst(rst), .bus(if_b.slave));
  run_length_detector #(.CH(1), .RUN_LEN(1), .MEALY(1), .CNT_W(CNT_W)) u_len1 (
    .clk(clk), .rst(rst), .bus(if_c.slave));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      run[i]     = 0;
      hits_ab[i] = 0;
    end
    hits_c = 0;
    mo_y   = '0;
    mo_det = '0;
  endtask

`ifdef RUN_DET_STATS_EN
  task automatic check_hits();
    logic [CH*CNT_W-1:0] exp_h;
    for (int i = 0; i < CH; i++) exp_h[i*CNT_W +: CNT_W] = CNT_W'(hits_ab[i]);
    check("hits_mealy", 32'(if_a.hits), 32'(exp_h));
    check("hits_moore", 32'(if_b.hits), 32'(exp_h));
    check("hits_len1",  32'(if_c.hits), 32'(hits_c));
  endtask
`endif

  // One sample cycle: drive at negedge, check same-cycle outputs, then check after the edge.
  task automatic step(input logic e, input logic c, input logic m, input logic [CH-1:0] xv,
                      output logic [CH-1:0] oya, output logic [CH-1:0] oda,
                      output logic [CH-1:0] oyb, output logic [CH-1:0] odb);
    int            nr [CH];
    logic [CH-1:0] eya, eda;
    logic          eyc;
    @(negedge clk);
    en = e; clr = c; mv = m; x = xv;
    #1;
    for (int i = 0; i < CH; i++) begin
      if (c)                 nr[i] = 0;
      else if (!e)           nr[i] = run[i];
      else if (xv[i] == m)   nr[i] = (run[i] < 1000) ? run[i] + 1 : run[i];
      else                   nr[i] = 0;
      eya[i] = e && !c && (nr[i] >= RL);
      eda[i] = e && !c && (nr[i] == RL);
    end
    eyc = e && !c && (nr[0] >= 1);
    oya = if_a.y_out;
    oda = if_a.det_pulse;
    check("mealy_y",    32'(if_a.y_out),     32'(eya));
    check("mealy_det",  32'(if_a.det_pulse), 32'(eda));
    check("len1_y",     32'(if_c.y_out),     32'(eyc));
    check("len1_det",   32'(if_c.det_pulse), 32'(eyc));
    check("moore_y_pre",   32'(if_b.y_out),     32'(mo_y));
    check("moore_det_pre", 32'(if_b.det_pulse), 32'(mo_det));
    @(posedge clk);
    #1;
    for (int i = 0; i < CH; i++) begin
      if (c) begin
        mo_y[i]   = 1'b0;
        mo_det[i] = 1'b0;
      end else if (e) begin
        mo_y[i]   = (nr[i] >= RL);
        mo_det[i] = (nr[i] == RL);
      end else begin
        mo_y[i]   = (run[i] >= RL);
        mo_det[i] = 1'b0;
      end
      if (eda[i] && hits_ab[i] < HMAX) hits_ab[i]++;
      run[i] = nr[i];
    end
    if (eyc && hits_c < HMAX) hits_c++;
    oyb = if_b.y_out;
    odb = if_b.det_pulse;
    check("moore_y",   32'(if_b.y_out),     32'(mo_y));
    check("moore_det", 32'(if_b.det_pulse), 32'(mo_det));
`ifdef RUN_DET_STATS_EN
    check_hits();
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    en = 1'b0; clr = 1'b0; rst = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  vec_t          tbl [NTBL];
  logic [11:0]   s_bits, y_bits, d_bits;
  logic [CH-1:0] oya, oda, oyb, odb;
  logic [2:0]    exp3;
  int            exp_hits [5];
  logic          rm;
  logic [CH-1:0] rx;

  initial begin
    rst = 1'b0; en = 1'b0; clr = 1'b0; mv = 1'b1; x = '0;
    model_reset();

    // Stream 0,1,1,1,1,1,0,1,0,1,1,1 (first sample in the MSB) and its expected flags.
    s_bits = 12'b0111_1101_0111;
    y_bits = 12'b0001_1100_0001;
    d_bits = 12'b0001_0000_0001;
    for (int k = 0; k < 12; k++) begin
      tbl[k]      = '{en: 1'b1, clr: 1'b0, mv: 1'b1, x: {~s_bits[11-k], s_bits[11-k]},
                      ey: {1'b0, y_bits[11-k]}, ed: {1'b0, d_bits[11-k]}};
      tbl[13 + k] = '{en: 1'b1, clr: 1'b0, mv: 1'b0, x: {~s_bits[11-k], s_bits[11-k]},
                      ey: {y_bits[11-k], 1'b0}, ed: {d_bits[11-k], 1'b0}};
    end
    tbl[12] = '{en: 1'b0, clr: 1'b1, mv: 1'b1, x: '0, ey: '0, ed: '0};

    #12;
    check("rst_mealy_y",   32'(if_a.y_out),     32'd0);
    check("rst_moore_y",   32'(if_b.y_out),     32'd0);
    check("rst_moore_det", 32'(if_b.det_pulse), 32'd0);
`ifdef RUN_DET_STATS_EN
    check_hits();
`endif
    @(negedge clk);
    rst = 1'b1;

    // Known stream: match=1 flags ch0, then after clr match=0 flags the inverted ch1.
    for (int i = 0; i < NTBL; i++) begin
      step(tbl[i].en, tbl[i].clr, tbl[i].mv, tbl[i].x, oya, oda, oyb, odb);
      check($sformatf("tbl%0d_mealy_y", i),   32'(oya), 32'(tbl[i].ey));
      check($sformatf("tbl%0d_mealy_det", i), 32'(oda), 32'(tbl[i].ed));
      check($sformatf("tbl%0d_moore_y", i),   32'(oyb), 32'(tbl[i].ey));
      check($sformatf("tbl%0d_moore_det", i), 32'(odb), 32'(tbl[i].ed));
    end

    // en gap: two ones, four disabled cycles with varying x, then one more enabled one.
    step(1'b0, 1'b1, 1'b1, 2'b00, oya, oda, oyb, odb);
    step(1'b1, 1'b0, 1'b1, 2'b01, oya, oda, oyb, odb);
    step(1'b1, 1'b0, 1'b1, 2'b01, oya, oda, oyb, odb);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, CH'($urandom), oya, oda, oyb, odb);
    step(1'b1, 1'b0, 1'b1, 2'b01, oya, oda, oyb, odb);
    check("gap_mealy_y",   32'(oya[0]), 32'd1);
    check("gap_mealy_det", 32'(oda[0]), 32'd1);
    check("gap_moore_y",   32'(oyb[0]), 32'd1);

    // clr at count 2 forces a fresh run of three.
    step(1'b0, 1'b1, 1'b1, 2'b00, oya, oda, oyb, odb);
    step(1'b1, 1'b0, 1'b1, 2'b01, oya, oda, oyb, odb);
    step(1'b1, 1'b0, 1'b1, 2'b01, oya, oda, oyb, odb);
    step(1'b1, 1'b1, 1'b1, 2'b01, oya, oda, oyb, odb);
    check("clr_mealy_y", 32'(oya[0]), 32'd0);
    exp3 = 3'b100;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b1, 2'b01, oya, oda, oyb, odb);
      check($sformatf("after_clr_y%0d", i), 32'(oya[0]), 32'(exp3[i]));
    end

    // Asynchronous reset mid-run while y_out is high.
    @(negedge clk);
    en = 1'b1; clr = 1'b0; mv = 1'b1; x = 2'b01;
    #1;
    check("pre_rst_mealy_y", 32'(if_a.y_out[0]), 32'd1);
    check("pre_rst_moore_y", 32'(if_b.y_out[0]), 32'd1);
    #1;
    rst = 1'b0;
    #1;
    check("async_rst_mealy_y",   32'(if_a.y_out),     32'd0);
    check("async_rst_mealy_det", 32'(if_a.det_pulse), 32'd0);
    check("async_rst_moore_y",   32'(if_b.y_out),     32'd0);
    check("async_rst_moore_det", 32'(if_b.det_pulse), 32'd0);
`ifdef RUN_DET_STATS_EN
    check("async_rst_hits_a", 32'(if_a.hits), 32'd0);
    check("async_rst_hits_b", 32'(if_b.hits), 32'd0);
    check("async_rst_hits_c", 32'(if_c.hits), 32'd0);
`endif
    model_reset();
    @(posedge clk);
    @(negedge clk);
    en = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b1, 2'b01, oya, oda, oyb, odb);
      check($sformatf("restart_y%0d", i), 32'(oya[0]), 32'(exp3[i]));
    end

    // Five separate runs of three: the detection counters saturate instead of wrapping.
    do_reset();
    exp_hits = '{1, 2, 3, 3, 3};
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 2'b01, oya, oda, oyb, odb);
      check($sformatf("run%0d_det", r), 32'(oda[0]), 32'd1);
`ifdef RUN_DET_STATS_EN
      check($sformatf("run%0d_hits_a", r), 32'(if_a.hits[CNT_W-1:0]), 32'(exp_hits[r]));
      check($sformatf("run%0d_hits_b", r), 32'(if_b.hits[CNT_W-1:0]), 32'(exp_hits[r]));
`endif
      step(1'b1, 1'b0, 1'b1, 2'b00, oya, oda, oyb, odb);
    end

    // Random traffic against the model, match_val changing occasionally mid-run.
    rm = 1'b1;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(39) == 0) rm = ~rm;
      for (int i = 0; i < CH; i++) rx[i] = ($urandom_range(3) != 0) ? rm : ~rm;
      step(($urandom_range(7) != 0), ($urandom_range(19) == 0), rm, rx, oya, oda, oyb, odb);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
